// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the memory-stage responder.
//   state_t     : responder FSM states (IDLE, BUSY, DONE)
//   DATA_W      : data and address width of the memory stage
//   CNT_W       : width of the wait-state down-counter
//   word_index  : byte address -> word index inside a memory of 2**addr_w words
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The byte offset in bits [1:0] is dropped, and everything above the
    // memory's own index bits is masked away; the caller decides separately
    // whether the address was in range.
    function automatic logic [DATA_W-1:0] word_index(
        input logic [DATA_W-1:0] addr,
        input int                addr_w
    );
        logic [DATA_W-1:0] mask;
        mask = (DATA_W'(1) << addr_w) - DATA_W'(1);
        return (addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Bundle between the M-stage pipeline register and the data-memory responder.
//   ALUOutM    : byte address of the access          (pipeline -> responder)
//   WriteDataM : store data                          (pipeline -> responder)
//   MemWriteM  : store request                       (pipeline -> responder)
//   MemtoRegM  : load request                        (pipeline -> responder)
//   ReadDataM  : registered load data                (responder -> pipeline)
//   StallM     : hold request to the pipeline        (responder -> pipeline)
//   MemDoneM   : one-cycle access-complete pulse     (responder -> pipeline)
//   MemFaultM  : sticky out-of-range flag, only present when DMEM_FAULT_EN
//                is defined                          (responder -> pipeline)
// Modports: master = pipeline side, slave = responder side.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
    import dmem_pkg::*;

    logic [DATA_W-1:0] ALUOutM;
    logic [DATA_W-1:0] WriteDataM;
    logic              MemWriteM;
    logic              MemtoRegM;
    logic [DATA_W-1:0] ReadDataM;
    logic              StallM;
    logic              MemDoneM;
`ifdef DMEM_FAULT_EN
    logic              MemFaultM;
`endif

    modport master (
        output ALUOutM, WriteDataM, MemWriteM, MemtoRegM,
        input  ReadDataM, StallM, MemDoneM
`ifdef DMEM_FAULT_EN
        , input MemFaultM
`endif
    );

    modport slave (
        input  ALUOutM, WriteDataM, MemWriteM, MemtoRegM,
        output ReadDataM, StallM, MemDoneM
`ifdef DMEM_FAULT_EN
        , output MemFaultM
`endif
    );

endinterface

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port word RAM: synchronous write, combinational read.
//   clk  : write clock
//   we   : write enable
//   addr : word index
//   wd   : write data
//   rd   : read data for addr (asynchronous)
// Contents are never cleared, not even by reset.
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
    end

    assign rd = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-stage responder: services each load/store from an internal word
// RAM after WAIT_CYCLES extra wait states, stalling the pipeline meanwhile.
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : dmem_responder_if.slave (address, data, requests, ReadDataM,
//            StallM, MemDoneM and, with DMEM_FAULT_EN, MemFaultM)
// Optional feature macro: DMEM_FAULT_EN adds the sticky MemFaultM flag that
// records any out-of-range access until reset.
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              commit;
    logic              req;
    logic              in_range;
    logic              we;
    logic [AW-1:0]     index;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] read_data;
`ifdef DMEM_FAULT_EN
    logic              fault;
`endif

    assign req      = bus.MemWriteM | bus.MemtoRegM;
    assign index    = AW'(word_index(bus.ALUOutM, AW));
    // Everything above the index bits must be zero to be in range.
    assign in_range = (bus.ALUOutM[DATA_W-1:AW+2] == '0);
    // A reset on the commit edge abandons the access, so the write is gated.
    assign we       = commit & bus.MemWriteM & in_range & ~reset;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .addr (index),
        .wd   (bus.WriteDataM),
        .rd   (rd_word)
    );

    // Next-state logic. commit marks the edge at which the access takes
    // effect; BUSY finishes even if req drops, using whatever is on the bus.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        commit     = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, counter and load-data registers. Loads read the pre-write word,
    // so a combined load+store returns the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            read_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (commit && bus.MemtoRegM) begin
                read_data <= in_range ? rd_word : '0;
            end
        end
    end

`ifdef DMEM_FAULT_EN
    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (commit && req && !in_range) begin
            fault <= 1'b1;
        end
    end

    assign bus.MemFaultM = fault;
`endif

    assign bus.ReadDataM = read_data;
    assign bus.StallM    = req & (state != DONE);
    assign bus.MemDoneM  = (state == DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Bench for dmem_responder: one instance with two wait states (dut2) driven
// from a vector table, one with zero wait states (dut0) for back-to-back
// accesses. Define DMEM_FAULT_EN to also check MemFaultM.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] exp_rd;
        logic        exp_fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cycle = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure spacing of done pulses.
    always @(posedge clk) cycle <= cycle + 1;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic r);
        if (sel) begin
            bus0.ALUOutM = a; bus0.WriteDataM = wd; bus0.MemWriteM = w; bus0.MemtoRegM = r;
        end else begin
            bus2.ALUOutM = a; bus2.WriteDataM = wd; bus2.MemWriteM = w; bus2.MemtoRegM = r;
        end
    endtask

    function automatic logic get_stall(input bit sel);
        return sel ? bus0.StallM : bus2.StallM;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? bus0.MemDoneM : bus2.MemDoneM;
    endfunction

    function automatic logic [31:0] get_rd(input bit sel);
        return sel ? bus0.ReadDataM : bus2.ReadDataM;
    endfunction

    // Drop both requests and let one clock pass.
    task automatic go_idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    // Present one access and hold it until the DONE cycle. If called during
    // a DONE cycle, the inputs are already presented there (back-to-back).
    // Returns in the DONE cycle with the number of stalled cycles seen.
    task automatic apply_stimulus(input bit sel, input logic [31:0] a,
                                  input logic [31:0] wd, input logic w, input logic r,
                                  output int stalls, output int done_cycle);
        drive(sel, a, wd, w, r);
        #1;
        if (get_done(sel)) begin
            @(posedge clk); #1;
        end
        stalls = 0;
        for (int i = 0; i < 40 && !get_done(sel); i++) begin
            if (get_stall(sel)) stalls++;
            @(posedge clk); #1;
        end
        done_cycle = cycle;
    endtask

    vec_t vecs[$];

    initial begin
        int stalls;
        int dc_a;
        int dc_b;

        vecs.push_back('{"st_10",      32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0});
        vecs.push_back('{"ld_10",      32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"st_00",      32'h00,  32'h11111111, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"ld_13",      32'h13,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"st_fc",      32'hFC,  32'hA5A5A5A5, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"ld_fc",      32'hFC,  32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 1'b0});
        vecs.push_back('{"st_20",      32'h20,  32'hCAFEF00D, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0});
        vecs.push_back('{"ld_00",      32'h00,  32'h0,        1'b0, 1'b1, 32'h11111111, 1'b0});
        vecs.push_back('{"ldst_10",    32'h10,  32'h0BADF00D, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"ld_10_new",  32'h10,  32'h0,        1'b0, 1'b1, 32'h0BADF00D, 1'b0});
        vecs.push_back('{"st_00_hold", 32'h00,  32'h12345678, 1'b1, 1'b0, 32'h0BADF00D, 1'b0});
        vecs.push_back('{"ld_oor",     32'h100, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1});
        vecs.push_back('{"st_oor",     32'h100, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{"ld_00_keep", 32'h00,  32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1});
        vecs.push_back('{"ld_fc_keep", 32'hFC,  32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 1'b1});
        vecs.push_back('{"ld_10_keep", 32'h10,  32'h0,        1'b0, 1'b1, 32'h0BADF00D, 1'b1});
        vecs.push_back('{"ld_20",      32'h20,  32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 1'b1});

        // Reset, then ten idle cycles with no request.
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_output("idle_stall", 32'(bus2.StallM),   32'h0);
            check_output("idle_rd",    bus2.ReadDataM,     32'h0);
            check_output("idle_done",  32'(bus2.MemDoneM), 32'h0);
`ifdef DMEM_FAULT_EN
            check_output("idle_fault", 32'(bus2.MemFaultM), 32'h0);
`endif
            @(posedge clk); #1;
        end

        // Table-driven accesses on the two-wait-state instance.
        foreach (vecs[i]) begin
            apply_stimulus(1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re,
                           stalls, dc_a);
            check_output({vecs[i].name, "_stalls"}, 32'(stalls), 32'd3);
            check_output({vecs[i].name, "_done"},   32'(bus2.MemDoneM), 32'h1);
            check_output({vecs[i].name, "_nostall"}, 32'(bus2.StallM), 32'h0);
            check_output({vecs[i].name, "_rd"},     bus2.ReadDataM, vecs[i].exp_rd);
`ifdef DMEM_FAULT_EN
            check_output({vecs[i].name, "_fault"},  32'(bus2.MemFaultM), 32'(vecs[i].exp_fault));
`endif
            go_idle();
            check_output({vecs[i].name, "_doneoff"}, 32'(bus2.MemDoneM), 32'h0);
        end

        // Reset during the second BUSY cycle of a store to 0x20.
        drive(1'b0, 32'h20, 32'h12345678, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_output("rst_busy1_stall", 32'(bus2.StallM), 32'h1);
        @(posedge clk); #1;
        check_output("rst_busy2_stall", 32'(bus2.StallM), 32'h1);
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_output("rst_stall", 32'(bus2.StallM),   32'h0);
        check_output("rst_done",  32'(bus2.MemDoneM), 32'h0);
        check_output("rst_rd",    bus2.ReadDataM,     32'h0);
`ifdef DMEM_FAULT_EN
        check_output("rst_fault", 32'(bus2.MemFaultM), 32'h0);
`endif
        // Next edge must not see a lingering BUSY/DONE state.
        @(posedge clk); #1;
        check_output("rst_done_after", 32'(bus2.MemDoneM), 32'h0);
        apply_stimulus(1'b0, 32'h20, 32'h0, 1'b0, 1'b1, stalls, dc_a);
        check_output("rst_ld20_stalls", 32'(stalls), 32'd3);
        check_output("rst_ld20_rd", bus2.ReadDataM, 32'hCAFEF00D);
        go_idle();

        // Zero wait states: back-to-back stores then back-to-back loads.
        apply_stimulus(1'b1, 32'h0, 32'h600DCAFE, 1'b1, 1'b0, stalls, dc_a);
        check_output("w0_st0_stalls", 32'(stalls), 32'd1);
        apply_stimulus(1'b1, 32'h4, 32'h0000BEEF, 1'b1, 1'b0, stalls, dc_b);
        check_output("w0_st4_stalls", 32'(stalls), 32'd1);
        check_output("w0_st_spacing", 32'(dc_b - dc_a), 32'd2);
        apply_stimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, stalls, dc_a);
        check_output("w0_ld0_stalls", 32'(stalls), 32'd1);
        check_output("w0_ld0_rd", bus0.ReadDataM, 32'h600DCAFE);
        apply_stimulus(1'b1, 32'h4, 32'h0, 1'b0, 1'b1, stalls, dc_b);
        check_output("w0_ld4_stalls", 32'(stalls), 32'd1);
        check_output("w0_ld4_rd", bus0.ReadDataM, 32'h0000BEEF);
        check_output("w0_ld_spacing", 32'(dc_b - dc_a), 32'd2);
        go_idle();
        check_output("w0_idle_done", 32'(bus0.MemDoneM), 32'h0);
        check_output("w0_hold_rd", get_rd(1'b1), 32'h0000BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
